sram_ctrl: RTL

//  Sequences the off-chip 16-bit SRAM on behalf of the MEM stage, serving the mem_r_en/mem_w_en requests the EXE stage produces.

---
 rtl/sram_ctrl_pkg.sv | 29 ++
 rtl/sram_wait_cnt.sv | 33 +++
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg -- shared definitions for the off-chip SRAM controller.
//   sram_state_t   : controller FSM states
//   SRAM_DW/CPU_DW : SRAM pad width and CPU word width
//   HALF_LO/HALF_HI: halfword select appended as the SRAM address LSB
//   addr_to_word() : CPU byte address -> SRAM word index (before truncation)
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } sram_state_t;

  localparam int SRAM_DW = 16;
  localparam int CPU_DW  = 32;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Word index relative to the SRAM window; caller truncates to its width.
  function automatic logic [31:0] addr_to_word(input logic [31:0] address,
                                                input logic [31:0] base);
    return (address - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt -- phase wait counter for the SRAM controller.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : return count to 0 on the next edge (wins over en)
//   en   : advance the count
//   cnt  : current count, 0..WAIT_CYC-1 within a phase
//   last : cnt is on the final cycle of a phase
module sram_wait_cnt
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       last
);

  localparam logic [3:0] LAST_VAL = 4'(WAIT_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl -- sequences a 16-bit asynchronous SRAM for 32-bit CPU accesses.
// Each word access is two halfword phases (low then high), each held for
// WAIT_CYC cycles; ready low freezes the pipeline while busy.
// Optional feature macro: SRAM_CTRL_BOUNDS_CHECK_EN (adds addr_err and
// rejects requests outside the SRAM window without touching the SRAM).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en, rd_en        : access requests, held until ready=1
//   address, write_data : CPU byte address and store data
//   read_data           : load data, valid while ready=1 after a read
//   ready               : 1 = idle or done, 0 = freeze
//   sram_addr           : halfword address {word, half}
//   sram_dq_out/_in/_oe : SRAM data pad out/in/output enable
//   sram_we_n           : active-low SRAM write enable
//   addr_err            : (bounds check builds only) out-of-window request
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW   = 18,
  parameter int WAIT_CYC  = 5,
  parameter int BASE_ADDR = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  localparam int WW = SRAM_AW - 1;
  // we_n is registered, so it is decided one cycle ahead: it rises when the
  // count is one short of the end. With WAIT_CYC=1 this value is never hit.
  localparam logic [3:0] PRELAST    = 4'(WAIT_CYC - 2);
  localparam logic       WE_N_ENTER = (WAIT_CYC == 1);

  sram_state_t   state;
  logic [3:0]    cnt;
  logic          last;
  logic          in_phase;
  logic [WW-1:0] word_idx;

  logic [WW-1:0] word_p0;
  logic [15:0]   wdata_hi_p0;
  logic [15:0]   rd_lo_p0;

  assign word_idx = WW'(addr_to_word(address, 32'(BASE_ADDR)));
  assign in_phase = (state == RD_LO) || (state == RD_HI) ||
                    (state == WR_LO) || (state == WR_HI);

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
  logic [31:0] word_full;
  logic        addr_bad;
  assign word_full = addr_to_word(address, 32'(BASE_ADDR));
  assign addr_bad  = (address < 32'(BASE_ADDR)) || ((word_full >> WW) != 32'd0);
`endif

  sram_wait_cnt #(
    .WAIT_CYC(WAIT_CYC)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_phase || last),
    .en  (in_phase),
    .cnt (cnt),
    .last(last)
  );

  assign ready = (state == DONE) || ((state == IDLE) && !rd_en && !wr_en);

  // Stage p0: request capture on acceptance; read low half held until commit
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      word_p0     <= word_idx;
      wdata_hi_p0 <= write_data[31:16];
    end
    if ((state == RD_LO) && last) begin
      rd_lo_p0 <= sram_dq_in;
    end
  end

  // Control FSM with registered SRAM pad outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
          if ((wr_en || rd_en) && addr_bad) begin
            state    <= DONE;
            addr_err <= 1'b1;
          end else
`endif
          if (wr_en) begin
            state       <= WR_LO;
            sram_addr   <= {word_idx, HALF_LO};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= WE_N_ENTER;
          end else if (rd_en) begin
            state     <= RD_LO;
            sram_addr <= {word_idx, HALF_LO};
          end
        end
        WR_LO: begin
          if (last) begin
            state       <= WR_HI;
            sram_addr   <= {word_p0, HALF_HI};
            sram_dq_out <= wdata_hi_p0;
            sram_we_n   <= WE_N_ENTER;
          end else begin
            sram_we_n <= (cnt == PRELAST);
          end
        end
        WR_HI: begin
          if (last) begin
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            sram_we_n <= (cnt == PRELAST);
          end
        end
        RD_LO: begin
          if (last) begin
            state     <= RD_HI;
            sram_addr <= {word_p0, HALF_HI};
          end
        end
        RD_HI: begin
          if (last) begin
            state     <= DONE;
            read_data <= {sram_dq_in, rd_lo_p0};
          end
        end
        DONE: begin
          state    <= IDLE;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
          addr_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
